uart_tx_top: RTL and testbench

//   Memory-mapped UART transmitter; a bus responder on the CPU data bus beside gpio_top/fact_top.
//   CPU stores bytes via addr_dec-qualified we; block queues them in a FIFO, serialises 8N1 on tx.

---
 rtl/uart_tx_top.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_top.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// rtl/uart_tx_top.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Register map: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL; read data is combinational on a.
module uart_tx_top #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             ovf, en;
  logic [DIV_W-1:0] div, div_lat, timer;
  logic [7:0]       shift;
  logic [2:0]       bitcnt;

  logic empty, full, data_wr, div_wr, ctrl_wr, push, flush, bit_end, pop;
  logic [3:0] cnt4;
  logic unused_bits;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign data_wr = we && (a == 2'd0);
  assign div_wr  = we && (a == 2'd2);
  assign ctrl_wr = we && (a == 2'd3);
  assign flush   = ctrl_wr && wd[2];
  assign push    = data_wr && !full;
  assign bit_end = (timer == '0);
  // A flush on the same edge keeps the queued head from being started.
  assign pop     = en && !empty && !flush &&
                   ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy    = (state != IDLE) || !empty;
  assign cnt4    = 4'(count);
  assign unused_bits = ^wd;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (data_wr && full)      ovf <= 1'b1;
      else if (ctrl_wr && wd[1]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en  <= 1'b1;
      div <= DIV_W'(DIV_RESET);
    end else begin
      if (ctrl_wr) en <= wd[0];
      if (div_wr)  div <= (wd[DIV_W-1:0] == '0) ? DIV_W'(1) : wd[DIV_W-1:0];
    end
  end

  // Each bit lasts div_lat cycles: timer is loaded with div_lat-1 and the bit ends at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      div_lat <= DIV_W'(1);
      shift   <= '0;
      bitcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            shift   <= mem[rptr];
            div_lat <= div;
            timer   <= div - 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx     <= shift[0];
            shift  <= shift >> 1;
            bitcnt <= '0;
            timer  <= div_lat - 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= div_lat - 1'b1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx     <= shift[0];
              shift  <= shift >> 1;
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state   <= START;
              tx      <= 1'b0;
              shift   <= mem[rptr];
              div_lat <= div;
              timer   <= div - 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (a)
      2'd1:    rd = {24'b0, ovf, busy, full, empty, cnt4};
      2'd2:    rd = 32'(div);
      2'd3:    rd = {31'b0, en};
      default: rd = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_top.sv
// tb/tb_uart_tx_top.sv - directed self-checking bench for uart_tx_top
module tb_uart_tx_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        busy;
  int checks = 0;
  int failures = 0;

  uart_tx_top #(.FIFO_DEPTH(8), .DIV_W(16), .DIV_RESET(434)) dut (
    .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .rd(rd), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; we = 1'b0; a = 2'd0; wd = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    a = 2'd1; #1;
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h10); end
    a = 2'd2; #1;
    checks++; if (rd !== 32'd434) begin failures++; $display("FAIL reset_div got=%0d exp=434", rd); end
    a = 2'd3; #1;
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL reset_ctrl got=%h exp=1", rd); end
    a = 2'd0; #1;
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_data_read got=%h exp=0", rd); end
  endtask

  task automatic test_basic_frame;
    wr(2'd2, 32'd4);
    a = 2'd2; #1;
    checks++; if (rd !== 32'd4) begin failures++; $display("FAIL div4_read got=%0d exp=4", rd); end
    wr(2'd0, 32'h55);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL pre_pop_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_pop_busy got=%b exp=1", busy); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== fbit(8'h55, i / 4)) begin
        failures++; $display("FAIL frame55 cyc=%0d got=%b exp=%b", i, tx, fbit(8'h55, i / 4));
      end
      if (i == 20) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame55_busy got=%b exp=1", busy); end
      end
    end
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL frame55_idle_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame55_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    wr(2'd3, 32'd0);
    for (int k = 0; k < 9; k++) wr(2'd0, 32'h10 + k);
    a = 2'd1; #1;
    checks++; if (rd !== 32'hE8) begin failures++; $display("FAIL ovf_status got=%h exp=%h", rd, 32'hE8); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL en0_tx got=%b exp=1", tx); end
    wr(2'd3, 32'd3);
    a = 2'd1; #1;
    checks++; if (rd !== 32'h68) begin failures++; $display("FAIL ovf_clear_status got=%h exp=%h", rd, 32'h68); end
    for (int f = 0; f < 8; f++) begin
      b = 8'h10 + 8'(f);
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        checks++;
        if (tx !== fbit(b, i / 4)) begin
          failures++; $display("FAIL fifo_frame%0d cyc=%0d got=%b exp=%b", f, i, tx, fbit(b, i / 4));
        end
      end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fifo_drain_busy got=%b exp=0", busy); end
    a = 2'd1; #1;
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL fifo_drain_status got=%h exp=%h", rd, 32'h10); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    wr(2'd2, 32'd2);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h3C);
    wr(2'd3, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      b = (i < 20) ? 8'hA5 : 8'h3C;
      checks++;
      if (tx !== fbit(b, (i % 20) / 2)) begin
        failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, tx, fbit(b, (i % 20) / 2));
      end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h00);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_data_tx got=%b exp=0", tx); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    a = 2'd1; #1;
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL rst_mid_status got=%h exp=%h", rd, 32'h10); end
    a = 2'd2; #1;
    checks++; if (rd !== 32'd434) begin failures++; $display("FAIL rst_mid_div got=%0d exp=434", rd); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_quiet cyc=%0d got=%b exp=1", i, tx); end
    end
  endtask

  task automatic test_div_change;
    wr(2'd2, 32'd0);
    a = 2'd2; #1;
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL div0_read got=%0d exp=1", rd); end
    wr(2'd0, 32'h0F);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== fbit(8'h0F, i)) begin failures++; $display("FAIL div1_frame cyc=%0d got=%b exp=%b", i, tx, fbit(8'h0F, i)); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div1_idle_busy got=%b exp=0", busy); end
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h33);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== fbit(8'h33, i / 2)) begin failures++; $display("FAIL div_mid_frame cyc=%0d got=%b exp=%b", i, tx, fbit(8'h33, i / 2)); end
      if (i == 4) begin a = 2'd2; wd = 32'd8; we = 1'b1; end
      if (i == 5) we = 1'b0;
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div_mid_idle_busy got=%b exp=0", busy); end
    a = 2'd2; #1;
    checks++; if (rd !== 32'd8) begin failures++; $display("FAIL div8_read got=%0d exp=8", rd); end
    wr(2'd0, 32'hC5);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== fbit(8'hC5, i / 8)) begin failures++; $display("FAIL div8_frame cyc=%0d got=%b exp=%b", i, tx, fbit(8'hC5, i / 8)); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div8_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_flush;
    wr(2'd2, 32'd2);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'hC3);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    a = 2'd1; #1;
    checks++; if (rd !== 32'h43) begin failures++; $display("FAIL flush_pre_status got=%h exp=%h", rd, 32'h43); end
    wr(2'd3, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== fbit(8'hC3, i / 2)) begin failures++; $display("FAIL flush_frame cyc=%0d got=%b exp=%b", i, tx, fbit(8'hC3, i / 2)); end
      if (i == 3) begin a = 2'd3; wd = 32'd5; we = 1'b1; end
      if (i == 4) begin we = 1'b0; a = 2'd1; end
      if (i == 5) begin
        #1;
        checks++; if (rd !== 32'h50) begin failures++; $display("FAIL flush_status got=%h exp=%h", rd, 32'h50); end
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL flush_quiet cyc=%0d got=%b exp=1", i, tx); end
    end
    a = 2'd1; #1;
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL flush_post_status got=%h exp=%h", rd, 32'h10); end
    a = 2'd3; #1;
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL flush_ctrl got=%h exp=1", rd); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_overflow;
    test_back_to_back;
    test_reset_mid_frame;
    test_div_change;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
